// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter
//   Two-port arbiter in front of a single data memory. Port A (core) and
//   port B (debug/DMA) raise req and hold it until ack. The winner's request
//   fields are latched, one command strobe is issued, reads wait out the
//   memory's stall handshake (high then low), and the owner gets a one-cycle
//   ack. A read whose stall handshake does not finish within STALL_TIMEOUT
//   wait cycles is aborted: rdata is forced to zero, timeout_err is set
//   (sticky until reset) and ack is still pulsed.
//
//   Optional feature: define DMEM_ARB_RR_EN for round-robin arbitration on
//   simultaneous requests. Without it, A always wins a tie.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   a_/b_req                 transfer request, held until ack
//   a_/b_memwrite            1 = write, 0 = read
//   a_/b_addr, a_/b_wdata    byte address, write data
//   a_/b_sign_mask           size/sign code passed through to memory
//   a_/b_ack                 one-cycle completion pulse
//   a_/b_rdata               read result, held until next read on that port
//   mem_addr/write_data/sign_mask  latched request fields (zero when idle)
//   mem_memwrite/memread     one-cycle command strobes
//   mem_read_data, mem_clk_stall   memory read result and stall flag
//   busy                     high whenever a transfer is in progress
//   timeout_err              sticky read-timeout flag
module data_mem_arbiter #(
   parameter int STALL_TIMEOUT = 15
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        a_req,
   input  logic        a_memwrite,
   input  logic [31:0] a_addr,
   input  logic [31:0] a_wdata,
   input  logic [3:0]  a_sign_mask,
   output logic        a_ack,
   output logic [31:0] a_rdata,
   input  logic        b_req,
   input  logic        b_memwrite,
   input  logic [31:0] b_addr,
   input  logic [31:0] b_wdata,
   input  logic [3:0]  b_sign_mask,
   output logic        b_ack,
   output logic [31:0] b_rdata,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_write_data,
   output logic [3:0]  mem_sign_mask,
   output logic        mem_memwrite,
   output logic        mem_memread,
   input  logic [31:0] mem_read_data,
   input  logic        mem_clk_stall,
   output logic        busy,
   output logic        timeout_err
);

   localparam int CNT_W = $clog2(STALL_TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STALL_TIMEOUT);

   typedef enum logic [2:0] {IDLE, ISSUE, RD_WAIT_HI, RD_WAIT_LO, DONE} state_t;

   state_t            state_q, state_d;
   logic              owner_q, owner_d;      // 0 = port A, 1 = port B
   logic [31:0]       addr_q, addr_d;
   logic [31:0]       wdata_q, wdata_d;
   logic [3:0]        mask_q, mask_d;
   logic              wr_q, wr_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [CNT_W-1:0]  cnt_inc;
   logic [31:0]       a_rdata_q, a_rdata_d;
   logic [31:0]       b_rdata_q, b_rdata_d;
   logic              tmo_q, tmo_d;
   logic              grant_b;
   logic              rd_done;
   logic [31:0]       rd_val;
`ifdef DMEM_ARB_RR_EN
   logic              rr_q, rr_d;            // 1 = B favoured on a tie
`endif

   always_comb begin
      state_d   = state_q;
      owner_d   = owner_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      mask_d    = mask_q;
      wr_d      = wr_q;
      cnt_d     = cnt_q;
      a_rdata_d = a_rdata_q;
      b_rdata_d = b_rdata_q;
      tmo_d     = tmo_q;
      rd_done   = 1'b0;
      rd_val    = 32'h0;
      cnt_inc   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
`ifdef DMEM_ARB_RR_EN
      rr_d      = rr_q;
      grant_b   = b_req && (!a_req || rr_q);
`else
      grant_b   = !a_req;
`endif

      case (state_q)
         IDLE: begin
            if (a_req || b_req) begin
               owner_d = grant_b;
               addr_d  = grant_b ? b_addr      : a_addr;
               wdata_d = grant_b ? b_wdata     : a_wdata;
               mask_d  = grant_b ? b_sign_mask : a_sign_mask;
               wr_d    = grant_b ? b_memwrite  : a_memwrite;
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            cnt_d   = '0;
            state_d = wr_q ? DONE : RD_WAIT_HI;
         end
         RD_WAIT_HI, RD_WAIT_LO: begin
            cnt_d = cnt_inc;
            // A normal handshake completion in the same cycle as the
            // timeout wins over the abort.
            if (state_q == RD_WAIT_HI && mem_clk_stall) begin
               state_d = RD_WAIT_LO;
            end else if (state_q == RD_WAIT_LO && !mem_clk_stall) begin
               rd_done = 1'b1;
               rd_val  = mem_read_data;
            end else if (cnt_inc == CNT_MAX) begin
               rd_done = 1'b1;
               rd_val  = 32'h0;
               tmo_d   = 1'b1;
            end
         end
         DONE: begin
            state_d = IDLE;
`ifdef DMEM_ARB_RR_EN
            rr_d    = !owner_q;
`endif
         end
         default: state_d = IDLE;
      endcase

      if (rd_done) begin
         state_d = DONE;
         if (owner_q) b_rdata_d = rd_val;
         else         a_rdata_d = rd_val;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         owner_q   <= 1'b0;
         addr_q    <= 32'h0;
         wdata_q   <= 32'h0;
         mask_q    <= 4'h0;
         wr_q      <= 1'b0;
         cnt_q     <= '0;
         a_rdata_q <= 32'h0;
         b_rdata_q <= 32'h0;
         tmo_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         owner_q   <= owner_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         mask_q    <= mask_d;
         wr_q      <= wr_d;
         cnt_q     <= cnt_d;
         a_rdata_q <= a_rdata_d;
         b_rdata_q <= b_rdata_d;
         tmo_q     <= tmo_d;
      end
   end

`ifdef DMEM_ARB_RR_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) rr_q <= 1'b0;
      else     rr_q <= rr_d;
   end
`endif

   // Every output is decoded from registered state, so an asynchronous
   // reset clears all of them immediately.
   assign busy           = (state_q != IDLE);
   assign mem_addr       = busy ? addr_q  : 32'h0;
   assign mem_write_data = busy ? wdata_q : 32'h0;
   assign mem_sign_mask  = busy ? mask_q  : 4'h0;
   assign mem_memwrite   = (state_q == ISSUE) &&  wr_q;
   assign mem_memread    = (state_q == ISSUE) && !wr_q;
   assign a_ack          = (state_q == DONE) && !owner_q;
   assign b_ack          = (state_q == DONE) &&  owner_q;
   assign a_rdata        = a_rdata_q;
   assign b_rdata        = b_rdata_q;
   assign timeout_err    = tmo_q;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// tb_data_mem_arbiter
//   Directed bench for data_mem_arbiter (STALL_TIMEOUT = 15). Inputs change
//   1 time unit after a rising edge and outputs are sampled at that point;
//   the memory's stall/data responses are driven by hand in the sequence.
module tb_data_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        a_req, a_memwrite, b_req, b_memwrite;
   logic [31:0] a_addr, a_wdata, b_addr, b_wdata;
   logic [3:0]  a_sign_mask, b_sign_mask;
   logic        a_ack, b_ack;
   logic [31:0] a_rdata, b_rdata;
   logic [31:0] mem_addr, mem_write_data, mem_read_data;
   logic [3:0]  mem_sign_mask;
   logic        mem_memwrite, mem_memread, mem_clk_stall;
   logic        busy, timeout_err;

   int n_cmp = 0;
   int n_err = 0;
   int n_ack;
   logic [31:0] exp_addr;

   always #5 clk = ~clk;

   data_mem_arbiter #(.STALL_TIMEOUT(15)) dut (
      .clk(clk), .rst(rst),
      .a_req(a_req), .a_memwrite(a_memwrite), .a_addr(a_addr),
      .a_wdata(a_wdata), .a_sign_mask(a_sign_mask), .a_ack(a_ack), .a_rdata(a_rdata),
      .b_req(b_req), .b_memwrite(b_memwrite), .b_addr(b_addr),
      .b_wdata(b_wdata), .b_sign_mask(b_sign_mask), .b_ack(b_ack), .b_rdata(b_rdata),
      .mem_addr(mem_addr), .mem_write_data(mem_write_data), .mem_sign_mask(mem_sign_mask),
      .mem_memwrite(mem_memwrite), .mem_memread(mem_memread),
      .mem_read_data(mem_read_data), .mem_clk_stall(mem_clk_stall),
      .busy(busy), .timeout_err(timeout_err)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   initial begin
      rst = 1'b1;
      a_req = 0; a_memwrite = 0; a_addr = 0; a_wdata = 0; a_sign_mask = 0;
      b_req = 0; b_memwrite = 0; b_addr = 0; b_wdata = 0; b_sign_mask = 0;
      mem_read_data = 32'h0; mem_clk_stall = 1'b0;
      #2;
      chk("rst_busy", busy, 0);
      chk("rst_acks", {a_ack, b_ack}, 0);
      chk("rst_strobes", {mem_memwrite, mem_memread}, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_tmo", timeout_err, 0);
      step(); step();
      rst = 1'b0;
      step();

      // A write: ack two edges after the request is sampled
      a_req = 1; a_memwrite = 1; a_addr = 32'h10; a_wdata = 32'hDEADBEEF; a_sign_mask = 4'b0100;
      step();
      chk("wr_strobe_w", mem_memwrite, 1);
      chk("wr_strobe_r", mem_memread, 0);
      chk("wr_addr", mem_addr, 32'h10);
      chk("wr_data", mem_write_data, 32'hDEADBEEF);
      chk("wr_mask", mem_sign_mask, 4'b0100);
      chk("wr_busy", busy, 1);
      chk("wr_ack_early", a_ack, 0);
      step();
      chk("wr_ack", a_ack, 1);
      chk("wr_strobe_once", mem_memwrite, 0);
      chk("wr_addr_held", mem_addr, 32'h10);
      a_req = 0;
      step();
      chk("wr_ack_1cyc", a_ack, 0);
      chk("wr_idle_busy", busy, 0);
      chk("wr_idle_addr", mem_addr, 0);

      // B read: memory raises stall one cycle after the strobe, for one cycle
      b_req = 1; b_memwrite = 0; b_addr = 32'h20; b_sign_mask = 4'b0010;
      step();
      chk("rd_strobe_r", mem_memread, 1);
      chk("rd_strobe_w", mem_memwrite, 0);
      chk("rd_addr", mem_addr, 32'h20);
      step();
      chk("rd_strobe_once", mem_memread, 0);
      step();
      chk("rd_wait_ack", b_ack, 0);
      mem_clk_stall = 1;
      step();
      chk("rd_stall_ack", b_ack, 0);
      mem_clk_stall = 0; mem_read_data = 32'h12345678;
      step();
      chk("rd_ack", b_ack, 1);
      chk("rd_a_ack", a_ack, 0);
      chk("rd_rdata", b_rdata, 32'h12345678);
      b_req = 0; mem_read_data = 32'hA5A5A5A5;
      step();
      chk("rd_ack_1cyc", b_ack, 0);
      chk("rd_rdata_hold", b_rdata, 32'h12345678);

      // Simultaneous requests, twice, with back-to-back re-grant
      a_req = 1; a_memwrite = 1; a_addr = 32'h100; a_wdata = 32'h1;
      b_req = 1; b_memwrite = 1; b_addr = 32'h200; b_wdata = 32'h2;
      step();
      chk("tie1_addr", mem_addr, 32'h100);
      step();
      chk("tie1_a_ack", a_ack, 1);
      chk("tie1_b_ack", b_ack, 0);
      step();
      chk("b2b_idle", busy, 0);
      step();
`ifdef DMEM_ARB_RR_EN
      exp_addr = 32'h200;
`else
      exp_addr = 32'h100;
`endif
      chk("tie2_addr", mem_addr, exp_addr);
      step();
      chk("tie2_a_ack", a_ack, (exp_addr == 32'h100) ? 1 : 0);
      chk("tie2_b_ack", b_ack, (exp_addr == 32'h200) ? 1 : 0);
      a_req = 0; b_req = 0;
      step();

      // B read with stall never rising: abort after 15 wait cycles
      b_req = 1; b_memwrite = 0; b_addr = 32'h30; mem_read_data = 32'hFFFFFFFF;
      n_ack = -1;
      step();
      for (int i = 2; i <= 40; i++) begin
         step();
         if (b_ack) begin
            n_ack = i;
            break;
         end
      end
      chk("tmo_latency", n_ack, 17);
      chk("tmo_err", timeout_err, 1);
      chk("tmo_rdata", b_rdata, 0);
      b_req = 0;
      step();
      chk("tmo_sticky", timeout_err, 1);

      // Reset while in RD_WAIT_LO
      a_req = 1; a_memwrite = 0; a_addr = 32'h40; mem_read_data = 32'h77;
      step();
      step();
      mem_clk_stall = 1;
      step();
      chk("rst_mid_busy", busy, 1);
      rst = 1;
      #1;
      chk("rstm_busy", busy, 0);
      chk("rstm_addr", mem_addr, 0);
      chk("rstm_tmo", timeout_err, 0);
      chk("rstm_rdata", {a_rdata, b_rdata}, 64'h0);
      mem_clk_stall = 0;
      step();
      chk("rstm_no_ack", a_ack, 0);
      rst = 0; a_req = 0;
      step();
      chk("rstm_still_idle", {busy, a_ack}, 0);

      // Normal service after reset
      b_req = 1; b_memwrite = 1; b_addr = 32'h50; b_wdata = 32'hCAFEF00D;
      step();
      chk("post_strobe", mem_memwrite, 1);
      chk("post_addr", mem_addr, 32'h50);
      step();
      chk("post_ack", b_ack, 1);
      b_req = 0;
      step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
